// File: rtl/mul_pkg.sv
// Shared constants and helpers for the multi512 product path.
package mul_pkg;

  localparam int MUL512_PROD_WIDTH = 1024;
  localparam int MUL512_LATENCY    = 4;
  localparam int MUL512_OUT_WIDTH  = 64;

  function automatic int beats(int prod_w, int out_w);
    return prod_w / out_w;
  endfunction

  localparam int MUL512_BEATS = beats(MUL512_PROD_WIDTH, MUL512_OUT_WIDTH);

  typedef logic [$clog2(MUL512_BEATS)-1:0] beat_idx_t;

endpackage

// File: rtl/mul_valid_pipe.sv
// Valid delay line matching the multiplier pipeline depth.
module mul_valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_i,
  output logic out_o
);

  logic [DEPTH-1:0] sr_q;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= in_i;
      end
    end else begin : g_many
      always_ff @(posedge clk) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= {sr_q[DEPTH-2:0], in_i};
      end
    end
  endgenerate

  assign out_o = sr_q[DEPTH-1];

endmodule

// File: rtl/mul_product_serializer.sv
// Captures multiplier products into a credit-limited buffer and
// streams each one out LSB-first as fixed-width beats.
module mul_product_serializer
  import mul_pkg::*;
#(
  parameter  int PROD_WIDTH  = MUL512_PROD_WIDTH,
  parameter  int OUT_WIDTH   = MUL512_OUT_WIDTH,
  parameter  int MUL_LATENCY = MUL512_LATENCY,
  parameter  int BUF_DEPTH   = 2,
  localparam int BEATS = beats(PROD_WIDTH, OUT_WIDTH),
  localparam int IW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [PROD_WIDTH-1:0] product,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [IW-1:0]         out_idx,
  output logic                  out_last,
  output logic                  overflow_err
);

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [PROD_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [CW-1:0] credits_q, credits_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] beat_q, beat_d;
  logic          ovf_q;

  logic acc, cap, hs, pop;
  logic [PROD_WIDTH-1:0] cur;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  mul_valid_pipe #(
    .DEPTH (MUL_LATENCY)
  ) u_vpipe (
    .clk   (clk),
    .rst_n (rst_n),
    .in_i  (acc),
    .out_o (cap)
  );

  assign issue_ready  = (credits_q != '0);
  assign acc          = issue_valid && issue_ready;
  assign out_valid    = (count_q != '0);
  assign cur          = mem_q[rd_ptr_q];
  // Gate data so the bus reads zero while nothing is buffered.
  assign out_data     = out_valid ? cur[beat_q*OUT_WIDTH +: OUT_WIDTH] : '0;
  assign out_idx      = beat_q;
  assign out_last     = out_valid && (beat_q == IW'(BEATS - 1));
  assign overflow_err = ovf_q;
  assign hs           = out_valid && out_ready;
  assign pop          = hs && out_last;

  always_comb begin
    credits_d = credits_q;
    count_d   = count_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    beat_d    = beat_q;
    if (acc) credits_d = credits_d - 1'b1;
    if (pop) credits_d = credits_d + 1'b1;
    if (cap) count_d = count_d + 1'b1;
    if (pop) count_d = count_d - 1'b1;
    if (cap) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (hs)  beat_d = out_last ? '0 : beat_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits_q <= CW'(BUF_DEPTH);
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      beat_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      credits_q <= credits_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      beat_q    <= beat_d;
      if (issue_valid && !issue_ready) ovf_q <= 1'b1;
      if (cap) mem_q[wr_ptr_q] <= product;
    end
  end

endmodule

// File: tb/tb_mul_product_serializer.sv
// Directed stimulus with a beat scoreboard and an independent monitor.
module tb_mul_product_serializer;
  import mul_pkg::*;

  localparam int L  = 4;
  localparam int NB = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             issue_valid;
  logic             issue_ready;
  logic [1023:0]    product;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  beat_idx_t        out_idx;
  logic             out_last;
  logic             overflow_err;

  mul_product_serializer #(
    .PROD_WIDTH  (1024),
    .OUT_WIDTH   (64),
    .MUL_LATENCY (L),
    .BUF_DEPTH   (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .product      (product),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: operand value emerges L edges later.
  logic [1023:0] op;
  logic [1023:0] pp [L];
  always @(posedge clk) begin
    pp[0] <= op;
    for (int i = 1; i < L; i++) pp[i] <= pp[i-1];
  end
  assign product = pp[L-1];

  typedef struct {
    logic [63:0] d;
    beat_idx_t   i;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    tb_cred = 2;
  logic  tb_ovf = 1'b0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1023:0] mk(logic [63:0] base, logic [63:0] inc);
    logic [1023:0] r;
    for (int i = 0; i < NB; i++) r[i*64 +: 64] = base + inc * 64'(i);
    return r;
  endfunction

  // Monitor: compares accepted beats and checks stall stability.
  logic        held_v = 1'b0;
  logic [63:0] held_d;
  beat_idx_t   held_i;
  logic        held_l;
  always @(negedge clk) begin
    beat_t e;
    if (rst_n && held_v) begin
      chk("stall_valid", 128'(out_valid), 128'(1));
      chk("stall_hold", {out_data, 4'(out_idx), out_last},
          {held_d, 4'(held_i), held_l});
    end
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 128'(out_data), 128'(0) - 1);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {out_data, 4'(out_idx), out_last},
            {e.d, 4'(e.i), e.l});
        if (e.l) tb_cred++;
      end
    end
    held_v = rst_n && out_valid && !out_ready;
    held_d = out_data;
    held_i = out_idx;
    held_l = out_last;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(logic [1023:0] val);
    beat_t b;
    issue_valid = 1'b1;
    op = val;
    chk("issue_ready", 128'(issue_ready), 128'(tb_cred != 0));
    if (tb_cred != 0) begin
      tb_cred--;
      for (int i = 0; i < NB; i++) begin
        b.d = val[i*64 +: 64];
        b.i = beat_idx_t'(i);
        b.l = (i == NB - 1);
        exp_q.push_back(b);
      end
    end else begin
      tb_ovf = 1'b1;
    end
  endtask

  task automatic issue(logic [1023:0] val);
    set_issue(val);
    step();
    issue_valid = 1'b0;
  endtask

  task automatic drain(bit toggle);
    logic [15:0] pat;
    int n;
    pat = 16'b1010_1100_1010_1100;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      if (toggle) out_ready = pat[n % 16];
      step();
      n++;
    end
    out_ready = 1'b1;
    chk("drain_timeout", 128'(n < 400), 128'(1));
  endtask

  task automatic wait_until_last();
    int n;
    n = 0;
    while (!(out_valid && out_last) && n < 100) begin
      step();
      n++;
    end
    chk("last_timeout", 128'(n < 100), 128'(1));
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    issue_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("rst_issue_ready", 128'(issue_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_idx", 128'(out_idx), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_overflow", 128'(overflow_err), 128'(0));

    // 1: single product, latency and streaming
    out_ready = 1'b1;
    issue(mk(64'h0, 64'h1));
    n = 0;
    while (!out_valid && n < 50) begin
      step();
      n++;
    end
    chk("latency", 128'(n), 128'(L));
    drain(1'b0);
    chk("t1_credit_back", 128'(issue_ready), 128'(1));

    // 2: fill credits while stalled, third issue dropped
    out_ready = 1'b0;
    issue(mk(64'hA000_0000_0000_0000, 64'h1));
    issue(mk(64'hB000_0000_0000_0000, 64'h1));
    chk("t2_no_credit", 128'(issue_ready), 128'(tb_cred != 0));
    issue(mk(64'hC000_0000_0000_0000, 64'h1));
    chk("t2_overflow", 128'(overflow_err), 128'(tb_ovf));
    repeat (8) step();
    out_ready = 1'b1;
    drain(1'b0);
    repeat (10) step();
    chk("t2_idle", 128'(out_valid), 128'(0));
    chk("t2_overflow_sticky", 128'(overflow_err), 128'(tb_ovf));

    // 3: backpressure pattern during one product
    out_ready = 1'b0;
    issue(mk(64'h3333_0000_0000_0000, 64'h0101));
    drain(1'b1);

    // 4: dropped issue alongside final beat with no credits
    out_ready = 1'b0;
    issue(mk(64'h4400_0000_0000_0000, 64'h1));
    issue(mk(64'h4500_0000_0000_0000, 64'h1));
    repeat (L + 1) step();
    out_ready = 1'b1;
    wait_until_last();
    set_issue(mk(64'h4600_0000_0000_0000, 64'h1));
    step();
    issue_valid = 1'b0;
    chk("t4_ready_after", 128'(issue_ready), 128'(tb_cred != 0));
    drain(1'b0);

    // 5: accepted issue alongside final beat with one credit
    out_ready = 1'b0;
    issue(mk(64'h5500_0000_0000_0000, 64'h1));
    repeat (L + 1) step();
    out_ready = 1'b1;
    wait_until_last();
    set_issue(mk(64'h5600_0000_0000_0000, 64'h1));
    step();
    issue_valid = 1'b0;
    chk("t5_ready_after", 128'(issue_ready), 128'(tb_cred != 0));
    drain(1'b0);

    // 6: all-ones then all-zeros
    issue(mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h0));
    issue(mk(64'h0, 64'h0));
    drain(1'b0);

    // 7: reset in the middle of a product with another in flight
    issue(mk(64'h7700_0000_0000_0000, 64'h1));
    n = 0;
    while (!(out_valid && out_idx == beat_idx_t'(7)) && n < 50) begin
      step();
      n++;
    end
    chk("t7_reach_beat7", 128'(n < 50), 128'(1));
    issue(mk(64'h7800_0000_0000_0000, 64'h1));
    rst_n = 1'b0;
    step();
    chk("t7_valid_low", 128'(out_valid), 128'(0));
    rst_n = 1'b1;
    exp_q.delete();
    tb_cred = 2;
    tb_ovf = 1'b0;
    chk("t7_issue_ready", 128'(issue_ready), 128'(1));
    chk("t7_overflow_clr", 128'(overflow_err), 128'(tb_ovf));
    repeat (12) step();
    chk("t7_no_ghost", 128'(out_valid), 128'(0));

    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
